// File: rtl/mem_access_ctrl.sv
// Data-SRAM access sequencer for the MEM stage: split-transaction req/addr_ok/data_ok
// handshake, byte-lane strobes and write-data replication, load extraction and alignment checks.
module mem_access_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_store,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rdata,
    output logic              out_ale,
    output logic              data_sram_req,
    output logic              data_sram_wr,
    output logic [1:0]        data_sram_size,
    output logic [3:0]        data_sram_wstrb,
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [DATA_W-1:0] data_sram_wdata,
    input  logic              data_sram_addr_ok,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state, state_nxt;
    logic              op_store;
    logic [1:0]        op_size;
    logic              op_unsigned;
    logic [ADDR_W-1:0] op_addr;
    logic [3:0]        op_wstrb;
    logic [DATA_W-1:0] op_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic              ale_q;
    logic              discard;

    logic              accept;
    logic              misaligned;
    logic [1:0]        size_norm;
    logic [3:0]        wstrb_in;
    logic [DATA_W-1:0] wdata_in;
    logic [DATA_W-1:0] rdata_shifted;
    logic [DATA_W-1:0] load_ext;

    always_comb begin
        in_ready = ~flush & ((state == IDLE) | ((state == DONE) & out_ready));
        accept   = in_valid & in_ready;
    end

    // Size 3 is folded into word so strobes, alignment and SRAM size agree.
    always_comb begin
        size_norm  = (in_size == 2'd3) ? 2'd2 : in_size;
        misaligned = 1'b0;
        wstrb_in   = 4'b1111;
        wdata_in   = in_wdata;
        unique case (size_norm)
            2'd0: begin
                wstrb_in = 4'b0001 << in_addr[1:0];
                wdata_in = {4{in_wdata[7:0]}};
            end
            2'd1: begin
                misaligned = in_addr[0];
                wstrb_in   = 4'b0011 << in_addr[1:0];
                wdata_in   = {2{in_wdata[15:0]}};
            end
            default: misaligned = (in_addr[1:0] != 2'b00);
        endcase
        if (!in_store) wstrb_in = 4'b0000;
    end

    always_comb begin
        rdata_shifted = data_sram_rdata >> {op_addr[1:0], 3'b000};
        unique case (op_size)
            2'd0:    load_ext = {{(DATA_W-8){~op_unsigned & rdata_shifted[7]}}, rdata_shifted[7:0]};
            2'd1:    load_ext = {{(DATA_W-16){~op_unsigned & rdata_shifted[15]}}, rdata_shifted[15:0]};
            default: load_ext = rdata_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = misaligned ? DONE : REQ;
            REQ: begin
                if (data_sram_addr_ok) state_nxt = WAIT;
                else if (flush)        state_nxt = IDLE;
            end
            WAIT: if (data_sram_data_ok) state_nxt = (discard | flush) ? IDLE : DONE;
            DONE: begin
                if (flush)          state_nxt = IDLE;
                else if (accept)    state_nxt = misaligned ? DONE : REQ;
                else if (out_ready) state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        data_sram_req   = (state == REQ);
        data_sram_wr    = op_store;
        data_sram_size  = op_size;
        data_sram_wstrb = op_wstrb;
        data_sram_addr  = op_addr;
        data_sram_wdata = op_wdata;
        out_valid       = (state == DONE);
        out_rdata       = rdata_q;
        out_ale         = ale_q;
    end

    // discard marks an issued transaction whose data_ok must be swallowed after a flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_store    <= 1'b0;
            op_size     <= '0;
            op_unsigned <= 1'b0;
            op_addr     <= '0;
            op_wstrb    <= '0;
            op_wdata    <= '0;
            rdata_q     <= '0;
            ale_q       <= 1'b0;
            discard     <= 1'b0;
        end else begin
            if (accept) begin
                op_store    <= in_store;
                op_size     <= size_norm;
                op_unsigned <= in_unsigned;
                op_addr     <= in_addr;
                op_wstrb    <= wstrb_in;
                op_wdata    <= wdata_in;
                rdata_q     <= '0;
                ale_q       <= misaligned;
            end
            if ((state == REQ) && flush && data_sram_addr_ok) discard <= 1'b1;
            if ((state == WAIT) && flush)                     discard <= 1'b1;
            if ((state == WAIT) && data_sram_data_ok && !discard && !flush)
                rdata_q <= op_store ? '0 : load_ext;
            if (state_nxt == IDLE) discard <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed handshake/flush/reset scenarios plus
// randomized loads and stores compared against an arithmetic reference model.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid, in_ready, in_store, in_unsigned, flush;
    logic [1:0]  in_size;
    logic [31:0] in_addr, in_wdata;
    logic        out_valid, out_ready, out_ale;
    logic [31:0] out_rdata;
    logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_store(in_store), .in_size(in_size),
        .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_ale(out_ale),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit model_misal(input logic [1:0] sz, input logic [31:0] a);
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] model_strb(input bit st, input logic [1:0] sz, input logic [31:0] a);
        int n;
        n = nbytes(sz);
        if (!st) return 4'd0;
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (nbytes(sz) == 1) return (wd % 256) * 32'h0101_0101;
        if (nbytes(sz) == 2) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input bit un,
                                               input logic [31:0] a, input logic [31:0] rd);
        longint v, range;
        logic [63:0] t;
        range = 64'sd1 << (8 * nbytes(sz));
        v = longint'({32'd0, rd}) / (64'sd1 << (8 * (a % 4)));
        v = v % range;
        if (!un && v >= range / 2) v = v - range;
        t = v;
        return t[31:0];
    endfunction

    // Issue one op from IDLE and play the SRAM side with the given addr_ok/data_ok/out_ready delays.
    task automatic run_op(input string tag, input bit st, input logic [1:0] sz, input bit un,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                          input int ad, input int dd, input int rdy);
        logic [31:0] exp_rd;
        exp_rd = st ? 32'd0 : model_load(sz, un, a, rd);
        in_valid = 1'b1; in_store = st; in_size = sz; in_unsigned = un;
        in_addr = a; in_wdata = wd; out_ready = 1'b1;
        #1 chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0; in_wdata = $urandom; in_addr = $urandom;
        if (model_misal(sz, a)) begin
            #1;
            chk({tag, "_ale_req"}, 32'(data_sram_req), 32'd0);
            chk({tag, "_ale_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_ale"}, 32'(out_ale), 32'd1);
            chk({tag, "_ale_rdata"}, out_rdata, 32'd0);
            @(negedge clk);
            #1 chk({tag, "_ale_idle"}, 32'(out_valid), 32'd0);
            return;
        end
        for (int k = 0; k <= ad; k++) begin
            data_sram_addr_ok = (k == ad);
            #1;
            chk({tag, "_req"}, 32'(data_sram_req), 32'd1);
            chk({tag, "_addr"}, data_sram_addr, a);
            chk({tag, "_wr"}, 32'(data_sram_wr), 32'(st));
            chk({tag, "_size"}, 32'(data_sram_size), (sz == 2'd3) ? 32'd2 : 32'(sz));
            chk({tag, "_wstrb"}, 32'(data_sram_wstrb), 32'(model_strb(st, sz, a)));
            if (st) chk({tag, "_wdata"}, data_sram_wdata, model_wdata(sz, wd));
            @(negedge clk);
        end
        data_sram_addr_ok = 1'b0;
        for (int j = 0; j <= dd; j++) begin
            data_sram_data_ok = (j == dd);
            data_sram_rdata   = (j == dd) ? rd : $urandom;
            #1;
            chk({tag, "_wait_req"}, 32'(data_sram_req), 32'd0);
            chk({tag, "_wait_valid"}, 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = $urandom;
        out_ready = (rdy == 0);
        #1;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_rdata"}, out_rdata, exp_rd);
        chk({tag, "_ale0"}, 32'(out_ale), 32'd0);
        for (int r = 0; r < rdy; r++) begin
            @(negedge clk);
            out_ready = (r == rdy - 1);
            #1;
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_rdata"}, out_rdata, exp_rd);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1 chk({tag, "_done_idle"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_store = 1'b0; in_size = 2'd0; in_unsigned = 1'b0;
        in_addr = '0; in_wdata = '0; flush = 1'b0; out_ready = 1'b1;
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        #12;
        chk("rst_req", 32'(data_sram_req), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ale", 32'(out_ale), 32'd0);
        chk("rst_rdata", out_rdata, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); resetn = 1'b1;
        @(negedge clk);

        run_op("ldw", 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
        run_op("stb", 1'b1, 2'd0, 1'b0, 32'h1003, 32'h0000_00A5, 32'h1111_1111, 0, 0, 0);
        run_op("ldh_s", 1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 32'h8001_1234, 0, 0, 0);
        run_op("ldh_u", 1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 32'h8001_1234, 0, 0, 0);
        run_op("ldb", 1'b0, 2'd0, 1'b0, 32'h2001, 32'h0, 32'h8001_1234, 0, 0, 0);
        run_op("misw", 1'b0, 2'd2, 1'b0, 32'h3002, 32'h0, 32'h0, 0, 0, 0);
        run_op("mish", 1'b0, 2'd1, 1'b0, 32'h3001, 32'h0, 32'h0, 0, 0, 0);
        run_op("stall", 1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 32'hCAFE_F00D, 4, 3, 2);
        run_op("sth3", 1'b1, 2'd1, 1'b0, 32'h4002, 32'h1234_BEEF, 32'h0, 1, 0, 0);
        run_op("sz3", 1'b1, 2'd3, 1'b0, 32'h4004, 32'h0102_0304, 32'h0, 0, 1, 1);

        // flush while waiting for data_ok: the returning data must be swallowed
        in_valid = 1'b1; in_store = 1'b0; in_size = 2'd2; in_addr = 32'h5000;
        @(negedge clk); in_valid = 1'b0; data_sram_addr_ok = 1'b1;
        @(negedge clk); data_sram_addr_ok = 1'b0; flush = 1'b1;
        #1 chk("fw_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk); flush = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234_5678;
        @(negedge clk); data_sram_data_ok = 1'b0;
        #1 chk("fw_no_valid", 32'(out_valid), 32'd0);
        chk("fw_idle", 32'(in_ready), 32'd1);
        @(negedge clk);
        #1 chk("fw_no_valid2", 32'(out_valid), 32'd0);
        run_op("after_fw", 1'b0, 2'd0, 1'b1, 32'h5003, 32'h0, 32'h9ABC_DEF0, 0, 0, 0);

        // flush in REQ without addr_ok, then a spurious data_ok in IDLE
        in_valid = 1'b1; in_addr = 32'h6000;
        @(negedge clk); in_valid = 1'b0; flush = 1'b1;
        #1 chk("fr_req", 32'(data_sram_req), 32'd1);
        @(negedge clk); flush = 1'b0;
        #1 chk("fr_req_drop", 32'(data_sram_req), 32'd0);
        data_sram_data_ok = 1'b1;
        @(negedge clk); data_sram_data_ok = 1'b0;
        #1 chk("spur_valid", 32'(out_valid), 32'd0);

        // flush in REQ coinciding with addr_ok: the issued transaction is discarded
        in_valid = 1'b1; in_addr = 32'h6100;
        @(negedge clk); in_valid = 1'b0; flush = 1'b1; data_sram_addr_ok = 1'b1;
        @(negedge clk); flush = 1'b0; data_sram_addr_ok = 1'b0;
        #1 chk("fra_req", 32'(data_sram_req), 32'd0);
        data_sram_data_ok = 1'b1;
        @(negedge clk); data_sram_data_ok = 1'b0;
        #1 chk("fra_valid", 32'(out_valid), 32'd0);

        // flush in DONE, then back-to-back accept out of DONE
        in_valid = 1'b1; in_size = 2'd2; in_addr = 32'h3002; out_ready = 1'b0;
        @(negedge clk); in_valid = 1'b0;
        #1 chk("fd_valid", 32'(out_valid), 32'd1);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        #1 chk("fd_drop", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_addr = 32'h3006;
        @(negedge clk); in_addr = 32'h7000; out_ready = 1'b1;
        #1 chk("b2b_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
        #1 chk("b2b_req", 32'(data_sram_req), 32'd1);
        chk("b2b_addr", data_sram_addr, 32'h7000);
        data_sram_addr_ok = 1'b1;
        @(negedge clk); data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BAD_CAFE;
        @(negedge clk); data_sram_data_ok = 1'b0; out_ready = 1'b1;
        #1 chk("b2b_rdata", out_rdata, 32'h0BAD_CAFE);
        chk("b2b_ale", 32'(out_ale), 32'd0);
        @(negedge clk);

        // asynchronous reset while the request is up
        in_valid = 1'b1; in_addr = 32'h8000;
        @(negedge clk); in_valid = 1'b0;
        #1 chk("ar_req", 32'(data_sram_req), 32'd1);
        resetn = 1'b0;
        #1 chk("ar_req_drop", 32'(data_sram_req), 32'd0);
        #1 resetn = 1'b1;
        @(negedge clk); data_sram_data_ok = 1'b1;
        @(negedge clk); data_sram_data_ok = 1'b0;
        #1 chk("ar_late_data", 32'(out_valid), 32'd0);
        chk("ar_req_idle", 32'(data_sram_req), 32'd0);
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            logic [1:0] sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes(sz) - 1);
            run_op("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                   $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
